// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage sequencer: one req/ack data memory access per load/store, with stall, timeout and access count
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 4,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m2reg,
    input  logic             wmem,
    input  logic             mem_ack,
    input  logic             err_clr,
    output logic             mem_req,
    output logic             mem_we,
    output logic             stall,
    output logic             mwb_bubble,
    output logic             busy,
    output logic             mem_err,
    output logic [ACC_W-1:0] acc_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] tcnt;
    logic             access;

    assign access = m2reg | wmem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b0;
            tcnt    <= '0;
            acc_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        state   <= ACCESS;
                        mem_req <= 1'b1;
                        // a malformed load+store is issued as a read
                        mem_we  <= wmem & ~m2reg;
                        tcnt    <= '0;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        acc_cnt <= acc_cnt + ACC_W'(1);
                    end else if (tcnt == TLAST) begin
                        state   <= ERR;
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    // returning to IDLE re-detects the frozen instruction and retries it
                    if (err_clr) begin
                        state   <= IDLE;
                        mem_err <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // release the pipeline only on the ack cycle so the instruction advances at that edge
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = access;
            ACCESS:  stall = ~mem_ack;
            ERR:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign mwb_bubble = stall;
    assign busy       = (state != IDLE);

endmodule
